reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of ROB entries; power of two, at least 4.
REQ-002 SHALL have parameter IDXW, default 4: log2(DEPTH), the width of the entry index.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports alloc_valid_1 / alloc_valid_2, input, 1 bit each: renamed instruction present in slot 1 / slot 2.
REQ-006 SHALL have ports alloc_rd_1 / alloc_rd_2, input, 5 bits: architectural destination register.
REQ-007 SHALL have ports alloc_pd_1 / alloc_pd_2, input, 6 bits: newly mapped physical destination.
REQ-008 SHALL have ports alloc_old_pd_1 / alloc_old_pd_2, input, 6 bits: previous mapping of rd, to be freed at retire.
REQ-009 SHALL have port alloc_ready, output, 1 bit: ROB can accept two instructions this cycle.
REQ-010 SHALL have ports rob_idx_1 / rob_idx_2, output, IDXW bits: entry index assigned to slot 1 / slot 2.
REQ-011 SHALL have ports complete_valid, input, 1 bit; complete_idx, input, IDXW bits; complete_value, input, 32 bits: the functional-unit writeback.
REQ-012 SHALL have ports retire_valid_1 / retire_valid_2, output, 1 bit: an instruction retired this cycle.
REQ-013 SHALL have ports retire_rd_1/_2 (5 bits), retire_pd_1/_2 (6 bits), retire_old_pd_1/_2 (6 bits) and retire_value_1/_2 (32 bits), all outputs: fields of each retired entry.
REQ-014 SHALL have ports count, output, IDXW+1 bits; empty, output, 1 bit; full, output, 1 bit.

Function
REQ-015 SHALL be a circular buffer with head and tail pointers of IDXW bits each; both wrap from DEPTH-1 to 0.
REQ-016 Each entry SHALL hold: busy, done, rd, pd, old_pd and a 32-bit value.
REQ-017 alloc_ready SHALL be combinational, equal to (count <= DEPTH-2), and evaluated on the registered count without crediting same-cycle retires.
REQ-018 rob_idx_1 SHALL equal tail and rob_idx_2 SHALL equal tail+1 mod DEPTH, combinationally.
REQ-019 Allocation SHALL occur at the edge only when alloc_ready=1; slot 1 is written at tail, and slot 2 is written at tail+1 only if alloc_valid_1=1.
REQ-020 alloc_valid_2 with alloc_valid_1=0 SHALL be ignored.
REQ-021 An allocated entry SHALL have busy=1 and done=0, and tail SHALL advance by the number of slots written (0, 1 or 2).
REQ-022 When alloc_ready=0, alloc inputs SHALL be ignored and no state SHALL change from allocation.
REQ-023 On complete_valid=1, the entry at complete_idx SHALL be updated with done=1 and value=complete_value.
REQ-024 A completion to a non-busy entry SHALL be ignored.
REQ-025 A completion to an entry being allocated in the same cycle SHALL be ignored; allocation wins.
REQ-026 Retire SHALL use the pre-edge state: slot 1 retires if entry[head] is busy and done.
REQ-027 Slot 2 SHALL retire only if slot 1 retires and entry[head+1] is busy and done.
REQ-028 Retirement SHALL be strictly in order; a not-done head blocks all younger entries.
REQ-029 Each retired entry SHALL be cleared to busy=0 and done=0, and head SHALL advance by the number retired.
REQ-030 retire_* outputs SHALL be registered: valid for exactly one cycle after the retiring edge, carrying the entry's fields.
REQ-031 retire_valid_* SHALL be 0 when nothing retires; the other retire fields then hold their last values.
REQ-032 A completion at edge N to the head entry SHALL produce retire_valid_1=1 in the cycle after edge N+1 (2-edge latency).
REQ-033 An entry with rd=0 SHALL retire normally with retire_rd=0; the consumer suppresses the register-file write and the free-pool release.
REQ-034 count SHALL update as count + allocated - retired, and simultaneous allocate and retire in one edge SHALL be exact.
REQ-035 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH).

Reset
REQ-036 rst_n=0 SHALL asynchronously clear head, tail, count, all busy/done bits and retire_valid_1/_2 to 0.
REQ-037 On reset, all other retire_* outputs SHALL clear to 0.
REQ-038 During reset, alloc_ready SHALL be 1, empty SHALL be 1 and full SHALL be 0.
REQ-039 Reset asserted mid-operation SHALL discard all in-flight entries; after rst_n rises, the first allocation SHALL land at index 0.

Verification
REQ-040 Dual allocation: alloc {rd=5,pd=33,old=5} and {rd=6,pd=34,old=6} -> rob_idx_1=0, rob_idx_2=1; count=2 next cycle.
REQ-041 Out-of-order completion: complete idx1 with value 0xBEEF -> no retire; then complete idx0 with 0x1234 -> two edges later, retire_valid_1=1 (rd 5, value 0x1234) and retire_valid_2=1 (rd 6, value 0xBEEF) in the same cycle.
REQ-042 Fill: allocate 14 entries -> alloc_ready=1; allocate 2 more -> full=1, alloc_ready=0; a further alloc request -> tail and count unchanged.
REQ-043 Wrap: with head=tail=15 and empty, allocate two -> rob_idx_1=15, rob_idx_2=0; complete both -> both retire and head=1.
REQ-044 Simultaneous events: count=15 with done head, alloc slot 1 only -> alloc rejected (alloc_ready=0), one retires, count=14.
REQ-045 Reset mid-operation: rst_n low with 6 busy entries -> count=0, retire_valid_*=0 immediately; a stale completion to idx 3 after reset -> ignored.

Source files
------------

// File: rtl/reorder_buffer.sv
// Dual-issue, dual-retire reorder buffer: allocates up to two renamed instructions per cycle,
// accepts one writeback per cycle and retires up to two completed entries strictly in order.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int IDXW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_valid_1,
    input  logic            alloc_valid_2,
    input  logic [4:0]      alloc_rd_1,
    input  logic [4:0]      alloc_rd_2,
    input  logic [5:0]      alloc_pd_1,
    input  logic [5:0]      alloc_pd_2,
    input  logic [5:0]      alloc_old_pd_1,
    input  logic [5:0]      alloc_old_pd_2,
    output logic            alloc_ready,
    output logic [IDXW-1:0] rob_idx_1,
    output logic [IDXW-1:0] rob_idx_2,
    input  logic            complete_valid,
    input  logic [IDXW-1:0] complete_idx,
    input  logic [31:0]     complete_value,
    output logic            retire_valid_1,
    output logic            retire_valid_2,
    output logic [4:0]      retire_rd_1,
    output logic [4:0]      retire_rd_2,
    output logic [5:0]      retire_pd_1,
    output logic [5:0]      retire_pd_2,
    output logic [5:0]      retire_old_pd_1,
    output logic [5:0]      retire_old_pd_2,
    output logic [31:0]     retire_value_1,
    output logic [31:0]     retire_value_2,
    output logic [IDXW:0]   count,
    output logic            empty,
    output logic            full
);

    localparam logic [IDXW:0] ALLOC_LIMIT = (IDXW+1)'(DEPTH - 2);
    localparam logic [IDXW:0] FULL_COUNT  = (IDXW+1)'(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [4:0]       ent_rd     [DEPTH];
    logic [5:0]       ent_pd     [DEPTH];
    logic [5:0]       ent_old_pd [DEPTH];
    logic [31:0]      ent_value  [DEPTH];

    logic [IDXW-1:0] head;
    logic [IDXW-1:0] tail;
    logic [IDXW-1:0] head_p1;
    logic [IDXW-1:0] tail_p1;
    logic            do_alloc_1;
    logic            do_alloc_2;
    logic            do_retire_1;
    logic            do_retire_2;
    logic            do_complete;
    logic [IDXW:0]   n_alloc;
    logic [IDXW:0]   n_retire;

    assign head_p1     = head + IDXW'(1);
    assign tail_p1     = tail + IDXW'(1);
    assign alloc_ready = (count <= ALLOC_LIMIT);
    assign rob_idx_1   = tail;
    assign rob_idx_2   = tail_p1;
    assign empty       = (count == '0);
    assign full        = (count == FULL_COUNT);

    // Slot 2 only rides along with slot 1, so allocation is always contiguous from tail.
    assign do_alloc_1  = alloc_ready && alloc_valid_1;
    assign do_alloc_2  = do_alloc_1 && alloc_valid_2;
    assign do_retire_1 = busy[head] && done[head];
    assign do_retire_2 = do_retire_1 && busy[head_p1] && done[head_p1];
    assign do_complete = complete_valid && busy[complete_idx]
                         && !(do_alloc_1 && (complete_idx == tail))
                         && !(do_alloc_2 && (complete_idx == tail_p1));

    assign n_alloc  = {{IDXW{1'b0}}, do_alloc_1}  + {{IDXW{1'b0}}, do_alloc_2};
    assign n_retire = {{IDXW{1'b0}}, do_retire_1} + {{IDXW{1'b0}}, do_retire_2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_complete) begin
                done[complete_idx] <= 1'b1;
            end
            if (do_retire_1) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
            end
            if (do_retire_2) begin
                busy[head_p1] <= 1'b0;
                done[head_p1] <= 1'b0;
            end
            if (do_alloc_1) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
            end
            if (do_alloc_2) begin
                busy[tail_p1] <= 1'b1;
                done[tail_p1] <= 1'b0;
            end
            head  <= head + n_retire[IDXW-1:0];
            tail  <= tail + n_alloc[IDXW-1:0];
            count <= count + n_alloc - n_retire;
        end
    end

    // Payload storage needs no reset: it is only read from entries whose busy bit is set.
    always_ff @(posedge clk) begin
        if (do_complete) begin
            ent_value[complete_idx] <= complete_value;
        end
        if (do_alloc_1) begin
            ent_rd[tail]     <= alloc_rd_1;
            ent_pd[tail]     <= alloc_pd_1;
            ent_old_pd[tail] <= alloc_old_pd_1;
        end
        if (do_alloc_2) begin
            ent_rd[tail_p1]     <= alloc_rd_2;
            ent_pd[tail_p1]     <= alloc_pd_2;
            ent_old_pd[tail_p1] <= alloc_old_pd_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_valid_1  <= 1'b0;
            retire_valid_2  <= 1'b0;
            retire_rd_1     <= '0;
            retire_rd_2     <= '0;
            retire_pd_1     <= '0;
            retire_pd_2     <= '0;
            retire_old_pd_1 <= '0;
            retire_old_pd_2 <= '0;
            retire_value_1  <= '0;
            retire_value_2  <= '0;
        end else begin
            retire_valid_1 <= do_retire_1;
            retire_valid_2 <= do_retire_2;
            if (do_retire_1) begin
                retire_rd_1     <= ent_rd[head];
                retire_pd_1     <= ent_pd[head];
                retire_old_pd_1 <= ent_old_pd[head];
                retire_value_1  <= ent_value[head];
            end
            if (do_retire_2) begin
                retire_rd_2     <= ent_rd[head_p1];
                retire_pd_2     <= ent_pd[head_p1];
                retire_old_pd_2 <= ent_old_pd[head_p1];
                retire_value_2  <= ent_value[head_p1];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a reference model tracks head/tail/count and a
// scoreboard queue of allocated entries that is popped whenever the DUT retires.
module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int IDXW  = 4;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid_1, alloc_valid_2;
    logic [4:0]  alloc_rd_1, alloc_rd_2;
    logic [5:0]  alloc_pd_1, alloc_pd_2;
    logic [5:0]  alloc_old_pd_1, alloc_old_pd_2;
    logic        alloc_ready;
    logic [3:0]  rob_idx_1, rob_idx_2;
    logic        complete_valid;
    logic [3:0]  complete_idx;
    logic [31:0] complete_value;
    logic        retire_valid_1, retire_valid_2;
    logic [4:0]  retire_rd_1, retire_rd_2;
    logic [5:0]  retire_pd_1, retire_pd_2;
    logic [5:0]  retire_old_pd_1, retire_old_pd_2;
    logic [31:0] retire_value_1, retire_value_2;
    logic [4:0]  count;
    logic        empty, full;

    reorder_buffer #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
        .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
        .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
        .alloc_old_pd_1(alloc_old_pd_1), .alloc_old_pd_2(alloc_old_pd_2),
        .alloc_ready(alloc_ready), .rob_idx_1(rob_idx_1), .rob_idx_2(rob_idx_2),
        .complete_valid(complete_valid), .complete_idx(complete_idx),
        .complete_value(complete_value),
        .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
        .retire_rd_1(retire_rd_1), .retire_rd_2(retire_rd_2),
        .retire_pd_1(retire_pd_1), .retire_pd_2(retire_pd_2),
        .retire_old_pd_1(retire_old_pd_1), .retire_old_pd_2(retire_old_pd_2),
        .retire_value_1(retire_value_1), .retire_value_2(retire_value_2),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [5:0]  old_pd;
        logic [31:0] value;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] m_busy, m_done;
    logic [3:0]  m_head, m_tail;
    int          m_count;
    int          n_checks = 0;
    int          n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_busy  = '0;
        m_done  = '0;
        m_head  = '0;
        m_tail  = '0;
        m_count = 0;
        sb_q.delete();
    endtask

    task automatic pop_compare(input string slot, input logic [4:0] rd, input logic [5:0] pd,
                               input logic [5:0] old_pd, input logic [31:0] value);
        sb_t e;
        check_output({"sb_nonempty_", slot}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_output({"ret_rd_", slot},     32'(rd),     32'(e.rd));
            check_output({"ret_pd_", slot},     32'(pd),     32'(e.pd));
            check_output({"ret_old_pd_", slot}, 32'(old_pd), 32'(e.old_pd));
            check_output({"ret_value_", slot},  value,       e.value);
        end
    endtask

    // One clock of stimulus: checks pre-edge outputs, advances the model, then checks post-edge.
    task automatic apply_stimulus(input logic a1, input logic a2,
                                  input logic [4:0] rd1, input logic [5:0] pd1, input logic [5:0] old1,
                                  input logic [4:0] rd2, input logic [5:0] pd2, input logic [5:0] old2,
                                  input logic cv, input logic [3:0] cidx, input logic [31:0] cval);
        logic       exp_ready, r1, r2;
        logic [3:0] h1;
        int         n_alloc, n_ret;
        alloc_valid_1 = a1;   alloc_valid_2 = a2;
        alloc_rd_1 = rd1;     alloc_pd_1 = pd1;     alloc_old_pd_1 = old1;
        alloc_rd_2 = rd2;     alloc_pd_2 = pd2;     alloc_old_pd_2 = old2;
        complete_valid = cv;  complete_idx = cidx;  complete_value = cval;

        exp_ready = (m_count <= DEPTH - 2);
        h1 = m_tail + 4'd1;
        check_output("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
        check_output("rob_idx_1", 32'(rob_idx_1), 32'(m_tail));
        check_output("rob_idx_2", 32'(rob_idx_2), 32'(h1));

        h1 = m_head + 4'd1;
        r1 = m_busy[m_head] && m_done[m_head];
        r2 = r1 && m_busy[h1] && m_done[h1];

        if (cv && m_busy[cidx]) begin
            m_done[cidx] = 1'b1;
            foreach (sb_q[i]) if (sb_q[i].idx == cidx) sb_q[i].value = cval;
        end

        n_ret = 0;
        if (r1) begin m_busy[m_head] = 1'b0; m_done[m_head] = 1'b0; n_ret++; end
        if (r2) begin m_busy[h1] = 1'b0; m_done[h1] = 1'b0; n_ret++; end
        m_head = m_head + 4'(n_ret);

        n_alloc = 0;
        if (exp_ready && a1) begin
            sb_q.push_back('{m_tail, rd1, pd1, old1, 32'd0});
            m_busy[m_tail] = 1'b1; m_done[m_tail] = 1'b0;
            m_tail = m_tail + 4'd1; n_alloc++;
            if (a2) begin
                sb_q.push_back('{m_tail, rd2, pd2, old2, 32'd0});
                m_busy[m_tail] = 1'b1; m_done[m_tail] = 1'b0;
                m_tail = m_tail + 4'd1; n_alloc++;
            end
        end
        m_count = m_count + n_alloc - n_ret;

        @(posedge clk);
        #1;
        check_output("retire_valid_1", 32'(retire_valid_1), 32'(r1));
        check_output("retire_valid_2", 32'(retire_valid_2), 32'(r2));
        if (retire_valid_1) pop_compare("1", retire_rd_1, retire_pd_1, retire_old_pd_1, retire_value_1);
        if (retire_valid_2) pop_compare("2", retire_rd_2, retire_pd_2, retire_old_pd_2, retire_value_2);
        check_output("count", 32'(count), 32'(m_count));
        check_output("empty", 32'(empty), 32'(m_count == 0));
        check_output("full",  32'(full),  32'(m_count == DEPTH));
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0);
    endtask

    task automatic complete(input logic [3:0] idx, input logic [31:0] val);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, idx, val);
    endtask

    task automatic alloc_pair(input logic [4:0] rd1, input logic [5:0] pd1, input logic [5:0] old1,
                              input logic [4:0] rd2, input logic [5:0] pd2, input logic [5:0] old2);
        apply_stimulus(1, 1, rd1, pd1, old1, rd2, pd2, old2, 0, 4'd0, 32'd0);
    endtask

    task automatic alloc_one(input logic [4:0] rd1, input logic [5:0] pd1, input logic [5:0] old1);
        apply_stimulus(1, 0, rd1, pd1, old1, 0, 0, 0, 0, 4'd0, 32'd0);
    endtask

    // Completes outstanding entries oldest-first until the model is empty (bounded).
    task automatic drain();
        logic       found;
        logic [3:0] c, idx;
        for (int k = 0; k < 80; k++) begin
            if (m_count == 0) break;
            found = 1'b0;
            idx   = '0;
            for (int j = 0; j < DEPTH; j++) begin
                c = m_head + 4'(j);
                if (!found && m_busy[c] && !m_done[c]) begin
                    found = 1'b1;
                    idx   = c;
                end
            end
            if (found) complete(idx, $urandom);
            else idle();
        end
        check_output("drain_empty", 32'(empty), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        check_output({tag, "_count"},       32'(count),          32'd0);
        check_output({tag, "_ret_valid_1"}, 32'(retire_valid_1), 32'd0);
        check_output({tag, "_ret_valid_2"}, 32'(retire_valid_2), 32'd0);
        check_output({tag, "_alloc_ready"}, 32'(alloc_ready),    32'd1);
        check_output({tag, "_empty"},       32'(empty),          32'd1);
        check_output({tag, "_full"},        32'(full),           32'd0);
        check_output({tag, "_ret_rd_1"},    32'(retire_rd_1),    32'd0);
        check_output({tag, "_ret_value_1"}, retire_value_1,      32'd0);
        check_output({tag, "_rob_idx_1"},   32'(rob_idx_1),      32'd0);
    endtask

    initial begin
        logic [3:0] base, cidx;
        logic       cv;

        rst_n = 1'b0;
        alloc_valid_1 = 0; alloc_valid_2 = 0;
        alloc_rd_1 = 0; alloc_rd_2 = 0; alloc_pd_1 = 0; alloc_pd_2 = 0;
        alloc_old_pd_1 = 0; alloc_old_pd_2 = 0;
        complete_valid = 0; complete_idx = 0; complete_value = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        rst_n = 1'b1;

        $display("[TB] dual allocation and out-of-order completion");
        alloc_pair(5'd5, 6'd33, 6'd5, 5'd6, 6'd34, 6'd6);
        check_output("dual_count", 32'(count), 32'd2);
        complete(4'd1, 32'hBEEF);
        check_output("ooo_no_retire", 32'(retire_valid_1), 32'd0);
        complete(4'd0, 32'h1234);
        check_output("ooo_latency_edge_n", 32'(retire_valid_1), 32'd0);
        idle();
        check_output("ooo_valid_1", 32'(retire_valid_1), 32'd1);
        check_output("ooo_rd_1",    32'(retire_rd_1),    32'd5);
        check_output("ooo_value_1", retire_value_1,      32'h1234);
        check_output("ooo_valid_2", 32'(retire_valid_2), 32'd1);
        check_output("ooo_rd_2",    32'(retire_rd_2),    32'd6);
        check_output("ooo_value_2", retire_value_2,      32'hBEEF);
        idle();
        check_output("hold_rd_1", 32'(retire_rd_1), 32'd5);

        $display("[TB] walk pointers to index 15 and wrap");
        for (int i = 0; i < 13; i++) alloc_one(5'(i + 1), 6'(40 + i), 6'(i + 1));
        drain();
        check_output("wrap_idx_1", 32'(rob_idx_1), 32'd15);
        check_output("wrap_idx_2", 32'(rob_idx_2), 32'd0);
        alloc_pair(5'd7, 6'd50, 6'd7, 5'd8, 6'd51, 6'd8);
        complete(4'd15, 32'hAAAA_0015);
        complete(4'd0,  32'hAAAA_0000);
        idle();
        check_output("wrap_empty", 32'(empty), 32'd1);
        check_output("wrap_head_1", 32'(rob_idx_1), 32'd1);

        $display("[TB] fill to full, including an rd=0 entry");
        for (int i = 0; i < 7; i++)
            alloc_pair(5'(2 * i), 6'(2 * i), 6'(32 + 2 * i), 5'(2 * i + 1), 6'(2 * i + 1), 6'(33 + 2 * i));
        check_output("fill14_ready", 32'(alloc_ready), 32'd1);
        alloc_pair(5'd20, 6'd20, 6'd60, 5'd21, 6'd21, 6'd61);
        check_output("fill16_full",  32'(full),        32'd1);
        check_output("fill16_ready", 32'(alloc_ready), 32'd0);
        alloc_pair(5'd22, 6'd22, 6'd62, 5'd23, 6'd23, 6'd63);
        check_output("fill_reject_count", 32'(count),     32'd16);
        check_output("fill_reject_tail",  32'(rob_idx_1), 32'd1);

        $display("[TB] simultaneous allocate request and retire at count 15");
        complete(4'd1, 32'h0000_0101);
        complete(4'd2, 32'h0000_0202);
        check_output("simul_count_15", 32'(count), 32'd15);
        check_output("simul_ready",    32'(alloc_ready), 32'd0);
        alloc_one(5'd24, 6'd24, 6'd24);
        check_output("simul_count_14", 32'(count), 32'd14);
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            cidx = 4'($urandom_range(0, 15));
            cv   = !(m_busy[cidx] && m_done[cidx]) && ($urandom_range(0, 3) != 0);
            apply_stimulus($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                           5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                           cv, cidx, $urandom);
        end
        drain();

        $display("[TB] reset mid-operation");
        base = m_tail;
        for (int i = 0; i < 4; i++)
            alloc_pair(5'(i + 9), 6'(i + 9), 6'(i + 9), 5'(i + 13), 6'(i + 13), 6'(i + 13));
        complete(base, 32'h5555_0000);
        complete(base + 4'd1, 32'h5555_0001);
        idle();
        check_output("pre_reset_count", 32'(count), 32'd6);
        check_output("pre_reset_valid", 32'(retire_valid_1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("mid");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        complete(4'd3, 32'hDEAD_BEEF);
        idle();
        check_output("stale_count", 32'(count), 32'd0);
        check_output("post_reset_idx", 32'(rob_idx_1), 32'd0);
        alloc_one(5'd17, 6'd45, 6'd17);
        complete(4'd0, 32'hCAFE_F00D);
        idle();
        check_output("post_reset_value", retire_value_1, 32'hCAFE_F00D);
        idle();
        check_output("sb_final_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
